// File: rtl/arb_pkg.sv
// Shared types and helpers for the RAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Bits needed to hold an index in 0..n-1 (never less than one bit).
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first candidate at or after 'start', wrapping around.
// Latency: purely combinational.
// Backpressure: none; 'found' is low when no unmasked request exists.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  input  logic [N-1:0]  excl,
  output logic [N-1:0]  win,
  output logic          found
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0]   cand;
  logic [N-1:0]   rot;
  logic [N-1:0]   oh;
  logic [2*N-1:0] wide;

  // Rotate so 'start' lands at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    cand  = req & ~excl;
    rot   = N'({cand, cand} >> start);
    oh    = rot & (~rot + ONE);
    wide  = {{N{1'b0}}, oh} << start;
    win   = wide[N-1:0] | wide[2*N-1:N];
    found = |cand;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin owner of a single-port sync-read RAM with bounded locked bursts.
// Latency: grant one cycle after req from idle, none on handover; read data one cycle after access.
// Backpressure: a requester holds req until served; a lock is cut after MAX_HOLD accesses if others wait.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ-1:0]        wren,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wrdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rdvalid,
  output logic [DATA_W-1:0]         rddata,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_wren,
  output logic [DATA_W-1:0]         mem_wrdata,
  input  logic [DATA_W-1:0]         mem_rddata,
  output logic                      rdy
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int HW = idx_w(MAX_HOLD);
  localparam logic [IW-1:0] PTR_LAST = IW'(NUM_REQ - 1);
  localparam logic [HW-1:0] HOLD_TOP = HW'(MAX_HOLD - 1);

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [NUM_REQ-1:0]   rd_tag_q, rd_tag_d;
  logic                 rdy_q, rdy_d;

  logic [NUM_REQ-1:0]   acc_vec;
  logic                 access;
  logic                 own_lock;
  logic                 own_wren;
  logic                 own_req;
  logic                 others;
  logic                 rel_a, rel_b, rel_c, rel;
  logic [IW-1:0]        own_idx;
  logic [IW-1:0]        base_idx;
  logic [IW-1:0]        pick_start;
  logic [NUM_REQ-1:0]   pick_win;
  logic                 pick_found;

  // Owner status and the three release conditions.
  always_comb begin
    acc_vec  = gnt_q & req;
    access   = |acc_vec;
    own_lock = |(gnt_q & lock);
    own_wren = |(acc_vec & wren);
    own_req  = |(gnt_q & req);
    others   = |(req & ~gnt_q);
    rel_a    = access & ~own_lock;
    rel_b    = (state_q == GRANT) & ~own_req;
    rel_c    = access & own_lock & (hold_q == HOLD_TOP) & others;
    rel      = rel_a | rel_b | rel_c;
  end

  // Encode the one-hot owner; also choose where the rotation starts.
  always_comb begin
    own_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_q[i]) own_idx = IW'(i);
    end
    base_idx   = (state_q == GRANT) ? own_idx : ptr_q;
    pick_start = (base_idx == PTR_LAST) ? '0 : base_idx + IW'(1);
  end

  // The owner is always masked: under release (b) its req is already low.
  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req   (req),
    .start (pick_start),
    .excl  (gnt_q),
    .win   (pick_win),
    .found (pick_found)
  );

  // Route the owner's access to the RAM; pins idle at zero otherwise.
  always_comb begin
    mem_addr   = '0;
    mem_wrdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc_vec[i]) begin
        mem_addr   = addr[i*ADDR_W +: ADDR_W];
        mem_wrdata = wrdata[i*DATA_W +: DATA_W];
      end
    end
    mem_wren = own_wren & ~rst;
  end

  // Next-state: arbitration, handover without bubble, hold counting, read tag.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    rd_tag_d = acc_vec & ~wren;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          gnt_d   = pick_win;
          hold_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (rel) begin
          ptr_d  = own_idx;
          hold_d = '0;
          if (pick_found) begin
            gnt_d   = pick_win;
            state_d = GRANT;
          end else begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end else if (access && (hold_q != HOLD_TOP)) begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    rdy_d = (state_d == IDLE);
  end

  // State registers; reset drops any grant and any pending read pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      ptr_q    <= PTR_LAST;
      hold_q   <= '0;
      rd_tag_q <= '0;
      rdy_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      ptr_q    <= ptr_d;
      hold_q   <= hold_d;
      rd_tag_q <= rd_tag_d;
      rdy_q    <= rdy_d;
    end
  end

  assign gnt     = gnt_q;
  assign rdvalid = rd_tag_q;
  assign rddata  = mem_rddata;
  assign rdy     = rdy_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Round-robin arbiter that shares one single-port 256x8 synchronous-read RAM (1-cycle read latency) between NUM_REQ engines, e.g. fill engine, key-schedule engine and host/debug port.
- Sits between the engines and the RAM instance and owns all RAM control pins.
- Supports locked bursts so an engine can do read-modify-write sequences atomically.
- Bounds the length of any locked burst so no other engine starves.

Parameters:
- NUM_REQ, 3, number of requesters (2..8); index 0 has top priority after reset.
- ADDR_W, 8, RAM address width.
- DATA_W, 8, RAM data width.
- MAX_HOLD, 16, maximum access cycles one grant may last while another requester waits (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req  in  NUM_REQ  per-requester request; held high until the access is done.
- lock  in  NUM_REQ  per-requester: keep the grant after this access.
- wren  in  NUM_REQ  per-requester write enable.
- addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- wrdata  in  NUM_REQ*DATA_W  flattened write data, packed the same way.
- gnt  out  NUM_REQ  one-hot-or-zero registered grant.
- rdvalid  out  NUM_REQ  one-cycle pulse to the requester whose read data is on rddata.
- rddata  out  DATA_W  shared read data, driven directly from mem_rddata.
- mem_addr  out  ADDR_W  RAM address.
- mem_wren  out  1  RAM write enable.
- mem_wrdata  out  DATA_W  RAM write data.
- mem_rddata  in  DATA_W  RAM read data; valid one cycle after the address.
- rdy  out  1  high when no grant is active (arbiter in IDLE).

Behaviour:
- Reset (rst high at a clock edge):
  - gnt=0, rdvalid=0, rdy=1, state=IDLE.
  - Round-robin pointer set to NUM_REQ-1, so requester 0 wins first.
  - Hold counter=0.
  - Reset mid-burst drops the grant and suppresses the pending rdvalid. The RAM write in the reset cycle is gated off, so mem_wren=0 whenever rst=1.
- States: IDLE and GRANT.
- IDLE:
  - If any req bit is high, pick the winner by rotating priority starting at pointer+1 (mod NUM_REQ).
  - Register gnt for the winner and move to GRANT; the first access happens the cycle after req is seen.
  - If no req bit is high, stay in IDLE.
- GRANT, owner k:
  - Access cycle = req[k] & gnt[k].
  - In an access cycle: mem_addr=addr[k], mem_wren=wren[k], mem_wrdata=wrdata[k], all combinational.
  - Outside an access cycle: mem_wren=0, and mem_addr/mem_wrdata are 0.
- Release of owner k happens at the clock edge ending the cycle when any of these holds:
  - (a) it is an access cycle with lock[k]=0;
  - (b) req[k]=0;
  - (c) hold counter = MAX_HOLD-1 in an access cycle while some other req bit is high.
- On release:
  - Pointer becomes k.
  - Re-arbitrate in the same edge over the current req bits, excluding k when releasing under (a) or (c).
  - If a winner exists, its gnt is registered at the same edge with no bubble cycle; otherwise go to IDLE.
  - Under (a) or (c), k may win again on a later arbitration once others have been served.
- Hold counter:
  - Increments on each access cycle of the current owner and clears on each grant change.
  - It saturates at MAX_HOLD-1 when no other requester waits, so a lone owner keeps its lock indefinitely.
- Reads:
  - A read access cycle (wren[k]=0) latches owner index k into a read-tag register.
  - Next cycle: rdvalid[k]=1 and rddata=mem_rddata, even if gnt has already moved to another requester.
  - Back-to-back reads give rdvalid on consecutive cycles.
- Writes produce no rdvalid.
- The RAM model is read-old-data, i.e. a read of an address written in the same cycle returns the old value.
- Requesters must not change addr/wren/wrdata/lock during an access cycle except at clock edges. A req bit dropping without a grant simply withdraws that request.
- rdy = (state==IDLE), registered, 1 after reset.

Decomposition:
- Package arb_pkg: state enum (IDLE, GRANT) and a clog2-based index-width constant helper.
- One sub-module, rr_pick: combinational rotating-priority picker.
  - Inputs: req vector, start index, exclude mask.
  - Outputs: one-hot winner and a found flag.
  - Instantiated once for both IDLE and release arbitration.
- Muxing, counter and read tag stay in mem_arbiter.

Test Plan:
- Reset then req=3'b111, lock=0, all reads:
  - Expected: gnt sequence 001, 010, 100, 001, one access each, no idle cycles between grants.
  - rdvalid pulses one cycle after each access carry the right owner bit.
- req[1] with lock=1 for 4 accesses (write 0x11..0x14 to addresses 0x20..0x23), then lock=0 on the 5th access (read 0x20):
  - Expected: gnt stays 010 for all 5 accesses; the read returns 0x11 with rdvalid=010.
- MAX_HOLD=16, req[0] locked continuously, req[2] raised at cycle 3:
  - Expected: gnt switches to 100 after exactly 16 accesses by requester 0.
  - With req[0] alone, it holds for 40 accesses with no forced release.
- Read by requester 2 in its last locked cycle, with grant passing to requester 0 the next cycle:
  - Expected: rdvalid=100 with mem_rddata in the same cycle that gnt=001 and requester 0 accesses.
- rst asserted mid-burst while requester 1 is writing:
  - Expected: mem_wren=0 in the reset cycle, gnt=0 and rdy=1 after the edge, no rdvalid.
  - Next request set 3'b110 → requester 1 wins first (pointer NUM_REQ-1).
- req[0] raised for one cycle then dropped before its access:
  - Expected: gnt=001 for one cycle with no RAM access (mem_wren=0), then release to IDLE and rdy=1.
